// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter: one register stage per log2 shift level.
// SLL/SRL/SRA/ROR with a sideband tag and a whole-pipeline stall.
module pipelined_shifter #(
  parameter int WIDTH   = 64,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter int TAG_W   = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_zero
);

  localparam int L = SHAMT_W;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  if (WIDTH < 8 || (WIDTH & (WIDTH - 1)) != 0
      || SHAMT_W != $clog2(WIDTH)) begin : g_bad_param
    $error("pipelined_shifter: bad WIDTH/SHAMT_W");
  end

  // Index k is the input of level k; index L is the last register.
  logic [L:0]                 vld_c;
  logic [L:0][WIDTH-1:0]      data_c;
  logic [L:0][1:0]            op_c;
  logic [L:0][SHAMT_W-1:0]    shamt_c;
  logic [L:0][TAG_W-1:0]      tag_c;
  logic                       advance;
  logic                       unused_tail;

  assign advance  = out_ready | ~vld_c[L];
  assign in_ready = advance;

  assign vld_c[0]   = in_valid;
  assign data_c[0]  = in_data;
  assign op_c[0]    = in_op;
  assign shamt_c[0] = in_shamt;
  assign tag_c[0]   = in_tag;

  for (genvar k = 0; k < L; k++) begin : g_lvl
    localparam int AMT = 1 << k;

    logic [WIDTH-1:0]   shf;
    logic               vld_q, vld_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [1:0]         op_q, op_d;
    logic [SHAMT_W-1:0] shamt_q, shamt_d;
    logic [TAG_W-1:0]   tag_q, tag_d;

    // SRA keeps the MSB at every level, so it is the original sign.
    always_comb begin
      shf = data_c[k];
      if (shamt_c[k][k]) begin
        case (op_c[k])
          OP_SLL:
            shf = {data_c[k][WIDTH-AMT-1:0], {AMT{1'b0}}};
          OP_SRL:
            shf = {{AMT{1'b0}}, data_c[k][WIDTH-1:AMT]};
          OP_SRA:
            shf = {{AMT{data_c[k][WIDTH-1]}},
                   data_c[k][WIDTH-1:AMT]};
          default:
            shf = {data_c[k][AMT-1:0],
                   data_c[k][WIDTH-1:AMT]};
        endcase
      end
    end

    always_comb begin
      vld_d   = vld_q;
      data_d  = data_q;
      op_d    = op_q;
      shamt_d = shamt_q;
      tag_d   = tag_q;
      if (advance) begin
        vld_d   = vld_c[k];
        data_d  = shf;
        op_d    = op_c[k];
        shamt_d = shamt_c[k];
        tag_d   = tag_c[k];
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        vld_q   <= 1'b0;
        data_q  <= '0;
        op_q    <= '0;
        shamt_q <= '0;
        tag_q   <= '0;
      end else begin
        vld_q   <= vld_d;
        data_q  <= data_d;
        op_q    <= op_d;
        shamt_q <= shamt_d;
        tag_q   <= tag_d;
      end
    end

    assign vld_c[k+1]   = vld_q;
    assign data_c[k+1]  = data_q;
    assign op_c[k+1]    = op_q;
    assign shamt_c[k+1] = shamt_q;
    assign tag_c[k+1]   = tag_q;
  end

  assign unused_tail = ^{op_c[L], shamt_c[L]};

  assign out_valid = vld_c[L];
  assign out_data  = data_c[L];
  assign out_tag   = tag_c[L];
  assign out_zero  = ~|data_c[L];

endmodule

// File: tb/tb_pipelined_shifter.sv
// Directed and randomised bench for pipelined_shifter.
// Scoreboard queue filled on accept, drained on emit.
module tb_pipelined_shifter;

  localparam int W  = 64;
  localparam int SW = 6;
  localparam int TW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [SW-1:0] in_shamt;
  logic [1:0]    in_op;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [TW-1:0] out_tag;
  logic          out_zero;

  pipelined_shifter #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_zero  (out_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  data;
    logic [TW-1:0] tag;
    int            cyc;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           fails  = 0;
  int           cyc    = 0;
  bit           chk_lat = 1'b0;
  logic [W-1:0] exp_next;

  function automatic logic [W-1:0] model(logic [W-1:0] d,
                                         logic [SW-1:0] s,
                                         logic [1:0] op);
    logic [W-1:0] r;
    case (op)
      2'b00: r = d << s;
      2'b01: r = d >> s;
      2'b10: r = W'($signed(d) >>> s);
      default: r = (s == 0) ? d : ((d >> s) | (d << (W - int'(s))));
    endcase
    return r;
  endfunction

  task automatic check(string name, logic [W-1:0] obs,
                       logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic sample(output bit acc);
    exp_t e;
    @(negedge clk);
    acc = in_valid && in_ready && !reset;
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("spurious_out", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("data", out_data, e.data);
        check("tag", W'(out_tag), W'(e.tag));
        check("zero", W'(out_zero), W'(e.data == '0));
        if (chk_lat) check("latency", W'(cyc - e.cyc), 64'd6);
      end
    end
    if (acc) begin
      e.data = exp_next;
      e.tag  = in_tag;
      e.cyc  = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(logic [W-1:0] d, logic [SW-1:0] s,
                      logic [1:0] op, logic [TW-1:0] tag,
                      logic [W-1:0] exp);
    bit acc;
    bit done = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_shamt = s;
    in_op    = op;
    in_tag   = tag;
    exp_next = exp;
    for (int i = 0; i < 50 && !done; i++) begin
      sample(acc);
      tick();
      done = acc;
    end
    if (!done) check("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    in_valid = 1'b0;
    for (int i = 0; i < 40 && sb.size() != 0; i++) begin
      sample(acc);
      tick();
    end
    check("drained", W'(sb.size()), 64'd0);
  endtask

  initial begin
    bit           acc;
    int           sent;
    int           n;
    bit           prev_stall;
    logic [W-1:0] hd;
    logic [TW-1:0] ht;
    logic [W-1:0] d;
    logic [SW-1:0] s;
    logic [1:0]   op;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shamt  = '0;
    in_op     = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    exp_next  = '0;
    tick();
    tick();
    reset = 1'b0;
    sample(acc);
    check("rst_valid", W'(out_valid), 64'd0);
    check("rst_data", out_data, 64'd0);
    check("rst_tag", W'(out_tag), 64'd0);
    check("rst_zero", W'(out_zero), 64'd1);
    check("rst_in_ready", W'(in_ready), 64'd1);
    tick();

    chk_lat = 1'b1;
    send(64'h1, 6'd0, 2'b00, 5'd1, 64'h1);
    send(64'h1, 6'd1, 2'b00, 5'd2, 64'h2);
    send(64'h1, 6'd63, 2'b00, 5'd3, 64'h8000_0000_0000_0000);
    drain();
    chk_lat = 1'b0;

    send(64'h4, 6'd1, 2'b01, 5'd4, 64'h2);
    send(64'h8000_0000_0000_0000, 6'd4, 2'b10, 5'd5,
         64'hF800_0000_0000_0000);
    send(64'h8000_0000_0000_0000, 6'd4, 2'b01, 5'd6,
         64'h0800_0000_0000_0000);
    send(64'h1, 6'd1, 2'b11, 5'd7, 64'h8000_0000_0000_0000);
    send(64'h1234_5678_9ABC_DEF0, 6'd16, 2'b11, 5'd8,
         64'hDEF0_1234_5678_9ABC);
    send(64'h1, 6'd63, 2'b00, 5'd9, 64'h8000_0000_0000_0000);
    send(64'h8000_0000_0000_0000, 6'd63, 2'b01, 5'd10, 64'h1);
    send(64'hFFFF_0000_0000_0000, 6'd63, 2'b10, 5'd11,
         64'hFFFF_FFFF_FFFF_FFFF);
    send(64'h0, 6'd5, 2'b11, 5'd12, 64'h0);
    drain();

    sent = 0;
    hd   = '0;
    ht   = '0;
    for (int i = 0; i < 60 && (sent < 10 || sb.size() != 0); i++) begin
      out_ready = !(i >= 7 && i <= 12);
      in_valid  = (sent < 10);
      in_data   = 64'h1;
      in_shamt  = SW'(sent);
      in_op     = 2'b00;
      in_tag    = TW'(sent + 16);
      exp_next  = 64'h1 << sent;
      sample(acc);
      if (i >= 7 && i <= 12) begin
        check("bp_in_ready", W'(in_ready), 64'd0);
        check("bp_valid", W'(out_valid), 64'd1);
      end
      if (i == 7) begin
        hd = out_data;
        ht = out_tag;
      end
      if (i > 7 && i <= 12) begin
        check("bp_hold_data", out_data, hd);
        check("bp_hold_tag", W'(out_tag), W'(ht));
      end
      if (acc) sent++;
      tick();
    end
    out_ready = 1'b1;
    check("bp_sent", W'(sent), 64'd10);
    drain();

    for (int i = 0; i < 3; i++)
      send(64'hFF << i, 6'd1, 2'b01, TW'(20 + i), 64'hFF << i >> 1);
    reset = 1'b1;
    tick();
    sb.delete();
    reset = 1'b0;
    sample(acc);
    check("mid_rst_valid", W'(out_valid), 64'd0);
    check("mid_rst_zero", W'(out_zero), 64'd1);
    check("mid_rst_data", out_data, 64'd0);
    tick();
    for (int i = 0; i < 8; i++) begin
      sample(acc);
      check("post_rst_quiet", W'(out_valid), 64'd0);
      tick();
    end
    chk_lat = 1'b1;
    send(64'h0F0F, 6'd4, 2'b00, 5'd30, 64'hF0F0);
    drain();
    chk_lat = 1'b0;

    n = 0;
    prev_stall = 1'b0;
    d  = '0;
    s  = '0;
    op = '0;
    for (int i = 0; i < 6000 && n < 1000; i++) begin
      if (!in_valid || acc) begin
        d  = ($urandom_range(0, 15) == 0) ? '0
             : {$urandom(), $urandom()};
        s  = SW'($urandom_range(0, W - 1));
        op = 2'($urandom_range(0, 3));
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = d;
      in_shamt  = s;
      in_op     = op;
      in_tag    = TW'($urandom());
      exp_next  = model(d, s, op);
      sample(acc);
      if (prev_stall) begin
        check("rnd_hold_data", out_data, hd);
        check("rnd_hold_tag", W'(out_tag), W'(ht));
      end
      prev_stall = out_valid && !out_ready;
      hd = out_data;
      ht = out_tag;
      if (acc) n++;
      tick();
    end
    check("rnd_count", W'(n), 64'd1000);
    out_ready = 1'b1;
    drain();

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
